// File: rtl/traffic_pkg.sv
// Shared definitions for the two-route light controller and its demand detector.
package traffic_pkg;

  // Lamp bit positions inside the 6-bit controller lamp vector {g1,y1,r1,g2,y2,r2}.
  localparam int G1 = 5;
  localparam int Y1 = 4;
  localparam int R1 = 3;
  localparam int G2 = 2;
  localparam int Y2 = 1;
  localparam int R2 = 0;

  // Controller state codes.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } ctrl_state_t;

  // Lamp vectors shown by the controller in S0..S3.
  localparam logic [5:0] LAMP_S0 = 6'b100001;
  localparam logic [5:0] LAMP_S1 = 6'b010001;
  localparam logic [5:0] LAMP_S2 = 6'b001100;
  localparam logic [5:0] LAMP_S3 = 6'b001010;

  // Which queue a drain tick applies to.
  typedef enum logic [1:0] {
    DRAIN_NONE = 2'd0,
    DRAIN_A    = 2'd1,
    DRAIN_B    = 2'd2
  } drain_sel_t;

  // Exactly one green lamp selects a route; both or neither green (yellow phase or
  // a corrupt vector) drains nothing.
  function automatic drain_sel_t drain_route(input logic [5:0] light);
    drain_sel_t sel;
    sel = DRAIN_NONE;
    if (light[G1] && !light[G2]) begin
      sel = DRAIN_A;
    end else if (light[G2] && !light[G1]) begin
      sel = DRAIN_B;
    end
    return sel;
  endfunction

endpackage

// File: rtl/traffic_demand_detector_if.sv
// Sensor/lamp inputs and demand outputs of the traffic demand detector.
interface traffic_demand_detector_if #(
  parameter int CNT_W = 8
);
  logic             sensor_a;
  logic             sensor_b;
  logic [5:0]       light;
  logic             traffic;
  logic [CNT_W-1:0] queue_a;
  logic [CNT_W-1:0] queue_b;
  logic             tick;

  // master: the environment driving sensors and lamps; slave: the detector.
  modport master (
    output sensor_a, sensor_b, light,
    input  traffic, queue_a, queue_b, tick
  );

  modport slave (
    input  sensor_a, sensor_b, light,
    output traffic, queue_a, queue_b, tick
  );
endinterface

// File: rtl/traffic_demand_detector_sensor_debounce.sv
// Loop-sensor conditioning: two-flop synchroniser, stability-count debounce and
// a one-clock rise strobe on each accepted 0->1 transition.
module sensor_debounce #(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int STAB_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  logic              sync_1;
  logic              sync_2;
  logic [STAB_W-1:0] stab;

  // Synchronise, count consecutive disagreeing samples, accept after DEB_CYC of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stab   <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      if (sync_2 != level) begin
        if (stab == STAB_W'(DEB_CYC - 1)) begin
          level <= sync_2;
          rise  <= sync_2;
          stab  <= '0;
        end else begin
          stab <= stab + STAB_W'(1);
        end
      end else begin
        stab <= '0;
      end
    end
  end

endmodule

// File: rtl/traffic_demand_detector.sv
// Demand detector feeding the light controller's 'traffic' input: per-route vehicle
// queues filled by debounced loop arrivals, drained on the green route once per tick,
// and a hysteretic, hold-limited LB-dominates decision.
module traffic_demand_detector
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEB_CYC  = 3,
  parameter int TICK_DIV = 3,
  parameter int HYST     = 2,
  parameter int MIN_HOLD = 4
) (
  input logic                        clk,
  input logic                        reset,
  traffic_demand_detector_if.slave   bus
);

  localparam int DIV_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] Q_MAX = {CNT_W{1'b1}};

  logic              level_a, level_b;
  logic              rise_a, rise_b;
  logic              arrive_a, arrive_b;
  logic              drain_a, drain_b;
  drain_sel_t        drain_sel;

  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic              tick_q;
  logic [CNT_W-1:0]  queue_a_q, queue_b_q;
  logic              traffic_q;
  logic [HOLD_W-1:0] hold_q;

  logic [CNT_W:0]    qa_ext, qb_ext, hyst_ext;
  logic              set_traffic, clr_traffic;

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sensor_a),
    .level (level_a),
    .rise  (rise_a)
  );

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sensor_b),
    .level (level_b),
    .rise  (rise_b)
  );

  // A rise is only ever reported together with a newly accepted high level.
  assign arrive_a = rise_a & level_a;
  assign arrive_b = rise_b & level_b;

  assign drain_sel = drain_route(bus.light);
  assign drain_a   = tick_q && (drain_sel == DRAIN_A);
  assign drain_b   = tick_q && (drain_sel == DRAIN_B);

  // Saturating up, floored down; simultaneous arrival and drain cancel out.
  function automatic logic [CNT_W-1:0] next_queue(input logic [CNT_W-1:0] q,
                                                  input logic arrive,
                                                  input logic drain);
    logic [CNT_W-1:0] n;
    n = q;
    if (arrive && !drain && q != Q_MAX) begin
      n = q + CNT_W'(1);
    end else if (drain && !arrive && q != '0) begin
      n = q - CNT_W'(1);
    end
    return n;
  endfunction

  // Next divider value; the registered tick is raised for the cycle the divider sits at its top.
  always_comb begin
    div_nxt = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
      div_nxt = '0;
    end
  end

  // Drain-tick divider and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick_q  <= (div_nxt == DIV_W'(TICK_DIV - 1));
    end
  end

  // Per-route vehicle queues.
  always_ff @(posedge clk) begin
    if (reset) begin
      queue_a_q <= '0;
      queue_b_q <= '0;
    end else begin
      queue_a_q <= next_queue(queue_a_q, arrive_a, drain_a);
      queue_b_q <= next_queue(queue_b_q, arrive_b, drain_b);
    end
  end

  // Compare one bit wider than the queues so queue + HYST cannot wrap.
  assign qa_ext   = {1'b0, queue_a_q};
  assign qb_ext   = {1'b0, queue_b_q};
  assign hyst_ext = (CNT_W + 1)'(HYST);

  assign set_traffic = !traffic_q && (hold_q == '0) && (qb_ext >= qa_ext + hyst_ext);
  assign clr_traffic =  traffic_q && (hold_q == '0) &&
                        ((qa_ext >= qb_ext + hyst_ext) || (queue_b_q == '0));

  // Traffic decision; a flip reloads the hold timer, which otherwise counts down on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      traffic_q <= 1'b0;
      hold_q    <= '0;
    end else if (set_traffic || clr_traffic) begin
      traffic_q <= ~traffic_q;
      hold_q    <= HOLD_W'(MIN_HOLD);
    end else if (tick_q && hold_q != '0) begin
      hold_q <= hold_q - HOLD_W'(1);
    end
  end

  assign bus.traffic = traffic_q;
  assign bus.queue_a = queue_a_q;
  assign bus.queue_b = queue_b_q;
  assign bus.tick    = tick_q;

endmodule
